// File: rtl/pc_predict_select_pkg.sv
// pc_predict_select_pkg: shared types, BTB entry layout and counter helper for the next-PC predictor
package pc_predict_select_pkg;
  localparam int TAG_W = 16;
  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;
  typedef logic [63:0] u64;
  typedef logic u1;
  typedef struct packed {
    u1 branch;
    u1 jump;
    u1 jalr;
  } control_t;
  typedef struct packed {
    u1 valid;
    logic [TAG_W-1:0] tag;
    u64 target;
    logic [1:0] ctr;
    u1 is_jump;
  } btb_entry_t;
  function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic up);
    return up ? (c == 2'b11 ? c : c + 2'b01) : (c == 2'b00 ? c : c - 2'b01);
  endfunction
endpackage

// File: rtl/pc_predict_select_btb_table.sv
// btb_table: direct-mapped BTB storage, two async read ports, one write port, single-cycle clear of all valid bits
module btb_table
  import pc_predict_select_pkg::*;
#(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_data,
  input  logic [IDX_W-1:0] rd_idx_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output btb_entry_t       rd_a,
  output btb_entry_t       rd_b
);
  btb_entry_t mem [ENTRIES];
  logic [ENTRIES-1:0] vld;
  // valid bits live in flops so the whole table invalidates in one cycle
  always_ff @(posedge clk)
    if (clr) vld <= '0;
    else if (we) vld[wr_idx] <= 1'b1;
  // payload carries no reset; a cleared valid bit hides stale contents
  always_ff @(posedge clk)
    if (we) mem[wr_idx] <= wr_data;
  // reads see the pre-write entry when indices collide
  always_comb begin
    rd_a = mem[rd_idx_a];
    rd_a.valid = vld[rd_idx_a];
    rd_b = mem[rd_idx_b];
    rd_b.valid = vld[rd_idx_b];
  end
endmodule

// File: rtl/pc_predict_select.sv
// pc_predict_select: fetch PC register with BTB prediction and execute-stage redirect; PERF_CNT_EN adds perf counters
module pc_predict_select
  import pc_predict_select_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int BTB_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_ready,
  output logic [63:0] pc_out,
  output logic        pc_valid,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        res_valid,
  input  logic [63:0] res_pc,
  input  control_t    res_ctl,
  input  logic        res_taken,
  input  logic [63:0] res_target,
  input  logic        res_pred_taken,
  input  logic [63:0] res_pred_target,
  output logic        redirect,
  output logic [63:0] redirect_pc,
  output logic [63:0] perf_branches,
  output logic [63:0] perf_mispredicts
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  btb_entry_t f_e, r_e, w_e;
  logic f_hit, r_hit, act_taken, we, unused_ok;
  u64 act_next;
  assign unused_ok = r_e.is_jump;
  btb_table #(.ENTRIES(BTB_ENTRIES)) u_btb (
    .clk(clk),
    .clr(!reset),
    .we(we),
    .wr_idx(res_pc[IDX_W+1:2]),
    .wr_data(w_e),
    .rd_idx_a(pc_out[IDX_W+1:2]),
    .rd_idx_b(res_pc[IDX_W+1:2]),
    .rd_a(f_e),
    .rd_b(r_e)
  );
  // fetch lookup, resolution compare and BTB write data
  always_comb begin
    f_hit = f_e.valid && f_e.tag == pc_out[IDX_W+2 +: TAG_W];
    r_hit = r_e.valid && r_e.tag == res_pc[IDX_W+2 +: TAG_W];
    pred_taken = reset && f_hit && (f_e.is_jump || f_e.ctr[1]);
    pred_target = !reset ? '0 : pred_taken ? f_e.target : pc_out + 64'd4;
    act_taken = res_ctl.jalr || res_ctl.jump || (res_ctl.branch && res_taken);
    act_next = res_ctl.jalr ? res_target & ~64'h1 : act_taken ? res_target : res_pc + 64'd4;
    redirect = reset && res_valid &&
               (act_taken != res_pred_taken || (act_taken && act_next != res_pred_target));
    redirect_pc = act_next;
    we = reset && res_valid &&
         (res_ctl.jump || res_ctl.jalr || (res_ctl.branch && (r_hit || res_taken)));
    w_e.valid = 1'b1;
    w_e.tag = res_pc[IDX_W+2 +: TAG_W];
    w_e.is_jump = res_ctl.jump || res_ctl.jalr;
    w_e.target = (w_e.is_jump || res_taken) ? act_next : r_e.target;
    w_e.ctr = w_e.is_jump ? 2'b11 : r_hit ? sat_ctr(r_e.ctr, res_taken) : 2'b10;
  end
  // redirect wins over stall; otherwise advance only on an accepted fetch
  always_ff @(posedge clk)
    if (!reset) begin
      pc_out <= PC_RESET;
      pc_valid <= 1'b0;
    end else begin
      pc_valid <= 1'b1;
      if (redirect) pc_out <= redirect_pc;
      else if (fetch_ready && pc_valid) pc_out <= pred_target;
    end
`ifdef PERF_CNT_EN
  // free-running event counters, wrapping at 2^64
  always_ff @(posedge clk)
    if (!reset) begin
      perf_branches <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (res_valid && (res_ctl.branch || res_ctl.jump || res_ctl.jalr)) perf_branches <= perf_branches + 64'd1;
      if (redirect) perf_mispredicts <= perf_mispredicts + 64'd1;
    end
`else
  assign perf_branches = '0;
  assign perf_mispredicts = '0;
`endif
endmodule

// File: tb/tb_pc_predict_select.sv
// tb_pc_predict_select: directed vector table plus reset and perf sequences for pc_predict_select
module tb_pc_predict_select;
  import pc_predict_select_pkg::*;
  localparam logic [63:0] P = 64'h8000_0000;
  localparam logic [2:0] B = 3'b100, JR = 3'b001, N = 3'b000;
  typedef struct {
    logic fr, rv;
    logic [63:0] rpc;
    logic [2:0] ctl;
    logic rt;
    logic [63:0] rtgt;
    logic rpt;
    logic [63:0] rptgt;
    logic [63:0] pc;
    logic pt;
    logic [63:0] ptgt;
    logic rd;
    logic [63:0] rdpc;
  } vec_t;
  logic clk = 0, reset = 0, fetch_ready = 0, res_valid = 0, res_taken = 0, res_pred_taken = 0;
  logic [63:0] res_pc = 0, res_target = 0, res_pred_target = 0;
  control_t res_ctl = '0;
  logic [63:0] pc_out, pred_target, redirect_pc, perf_branches, perf_mispredicts;
  logic pc_valid, pred_taken, redirect;
  int n_chk = 0, n_fail = 0;
  vec_t v [24];
  always #5 clk = ~clk;
  pc_predict_select dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready),
    .pc_out(pc_out), .pc_valid(pc_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .res_valid(res_valid), .res_pc(res_pc), .res_ctl(res_ctl), .res_taken(res_taken),
    .res_target(res_target), .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic fr, input logic rv, input logic [63:0] rpc, input logic [2:0] ctl,
                       input logic rt, input logic [63:0] rtgt, input logic rpt, input logic [63:0] rptgt);
    fetch_ready = fr;
    res_valid = rv;
    res_pc = rpc;
    res_ctl = control_t'(ctl);
    res_taken = rt;
    res_target = rtgt;
    res_pred_taken = rpt;
    res_pred_target = rptgt;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    v[0]  = '{1, 0, 0, N, 0, 0, 0, 0, P, 0, P + 4, 0, 0};
    v[1]  = '{1, 0, 0, N, 0, 0, 0, 0, P + 4, 0, P + 8, 0, 0};
    v[2]  = '{1, 0, 0, N, 0, 0, 0, 0, P + 8, 0, P + 'hC, 0, 0};
    v[3]  = '{0, 0, 0, N, 0, 0, 0, 0, P + 'hC, 0, P + 'h10, 0, 0};
    v[4]  = '{0, 0, 0, N, 0, 0, 0, 0, P + 'hC, 0, P + 'h10, 0, 0};
    v[5]  = '{0, 1, P + 'h10, B, 1, P + 'h100, 0, P + 'h14, P + 'hC, 0, P + 'h10, 1, P + 'h100};
    v[6]  = '{0, 1, P + 'hC, N, 0, 0, 1, P + 'h100, P + 'h100, 0, P + 'h104, 1, P + 'h10};
    v[7]  = '{0, 0, 0, N, 0, 0, 0, 0, P + 'h10, 1, P + 'h100, 0, 0};
    for (int i = 8; i < 12; i++)
      v[i] = '{0, 1, P + 'h10, B, 1, P + 'h100, 1, P + 'h100, P + 'h10, 1, P + 'h100, 0, 0};
    v[12] = '{0, 1, P + 'h10, B, 0, P + 'h100, 1, P + 'h100, P + 'h10, 1, P + 'h100, 1, P + 'h14};
    v[13] = '{0, 1, P + 'hC, N, 0, 0, 1, P + 'h100, P + 'h14, 0, P + 'h18, 1, P + 'h10};
    v[14] = '{0, 0, 0, N, 0, 0, 0, 0, P + 'h10, 1, P + 'h100, 0, 0};
    v[15] = v[12];
    v[16] = v[13];
    v[17] = '{0, 0, 0, N, 0, 0, 0, 0, P + 'h10, 0, P + 'h14, 0, 0};
    v[18] = '{0, 1, P + 'h20, JR, 0, P + 'h203, 0, P + 'h24, P + 'h10, 0, P + 'h14, 1, P + 'h202};
    v[19] = '{0, 0, 0, N, 0, 0, 0, 0, P + 'h202, 0, P + 'h206, 0, 0};
    v[20] = '{0, 1, P + 'h1C, N, 0, 0, 1, 0, P + 'h202, 0, P + 'h206, 1, P + 'h20};
    v[21] = '{1, 0, 0, N, 0, 0, 0, 0, P + 'h20, 1, P + 'h202, 0, 0};
    v[22] = '{0, 1, P + 'h20, JR, 0, P + 'h203, 1, P + 'h202, P + 'h202, 0, P + 'h206, 0, 0};
    v[23] = '{0, 1, P + 'h10, B, 1, P + 'h100, 1, P + 'h200, P + 'h202, 0, P + 'h206, 1, P + 'h100};
    drive(0, 1, P + 'h10, B, 1, P + 'h100, 0, P + 'h14);
    @(negedge clk);
    chk("redirect_in_reset", redirect, 0);
    repeat (3) tick();
    chk("reset_pc", pc_out, P);
    chk("reset_pc_valid", pc_valid, 0);
    chk("reset_pred_taken", pred_taken, 0);
    drive(0, 0, 0, N, 0, 0, 0, 0);
    reset = 1;
    tick();
    chk("release_pc_valid", pc_valid, 1);
    chk("release_pred_taken", pred_taken, 0);
    for (int i = 0; i < 24; i++) begin
      drive(v[i].fr, v[i].rv, v[i].rpc, v[i].ctl, v[i].rt, v[i].rtgt, v[i].rpt, v[i].rptgt);
      #1;
      chk($sformatf("v%0d_pc", i), pc_out, v[i].pc);
      chk($sformatf("v%0d_pred_taken", i), pred_taken, v[i].pt);
      chk($sformatf("v%0d_pred_target", i), pred_target, v[i].ptgt);
      chk($sformatf("v%0d_redirect", i), redirect, v[i].rd);
      if (v[i].rd) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, v[i].rdpc);
      tick();
    end
    drive(0, 0, 0, N, 0, 0, 0, 0);
    chk("table_final_pc", pc_out, P + 'h100);
`ifdef PERF_CNT_EN
    chk("table_perf_branches", perf_branches, 10);
    chk("table_perf_mispredicts", perf_mispredicts, 9);
`else
    chk("table_perf_branches", perf_branches, 0);
    chk("table_perf_mispredicts", perf_mispredicts, 0);
`endif
    reset = 0;
    drive(0, 1, P + 'h10, B, 1, P + 'h300, 0, P + 'h14);
    #1;
    chk("midreset_redirect", redirect, 0);
    chk("midreset_pred_taken", pred_taken, 0);
    tick();
    drive(0, 0, 0, N, 0, 0, 0, 0);
    chk("midreset_pc", pc_out, P);
    chk("midreset_pc_valid", pc_valid, 0);
    chk("midreset_perf_branches", perf_branches, 0);
    chk("midreset_perf_mispredicts", perf_mispredicts, 0);
    reset = 1;
    tick();
    chk("rerelease_pc_valid", pc_valid, 1);
    fetch_ready = 1;
    repeat (4) tick();
    fetch_ready = 0;
    #1;
    chk("cleared_pc", pc_out, P + 'h10);
    chk("cleared_pred_taken", pred_taken, 0);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(0, 1, P + 'h40, B, 0, P + 'h80, 0, 0);
      else drive(0, 1, P + 'h40, B, 1, P + 'h80, 0, P + 'h44);
      #1;
      chk($sformatf("perf_seq%0d_redirect", i), redirect, i >= 3);
      tick();
    end
    drive(0, 0, 0, N, 0, 0, 0, 0);
`ifdef PERF_CNT_EN
    chk("perf_branches", perf_branches, 5);
    chk("perf_mispredicts", perf_mispredicts, 2);
`else
    chk("perf_branches", perf_branches, 0);
    chk("perf_mispredicts", perf_mispredicts, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
